axis_pattern_generator_mm: RTL
==============================

# axis_pattern_generator_mm

Multi-mode AXI4-Stream test pattern source for bring-up and datapath verification. It emits one beat every DIVIDER enabled clocks, selecting between counter, PRBS-31, walking-one and constant patterns. Beats are grouped into fixed-length packets with TLAST. The AXIS handshake is fully compliant, and beats that cannot be delivered are counted rather than overwritten. It sits at the head of a stream datapath in place of a real source.

## Interface
- TDATA_WIDTH, 32: stream data width; minimum 8.
- COUNTER_START, 0: first and wrap value of counter mode.
- COUNTER_END, 255: last value of counter mode; must be ≥ COUNTER_START.
- COUNTER_INCR, 1: counter step; minimum 1.
- DIVIDER, 5: enabled clocks per generated beat; minimum 1.
- PACKET_LEN, 16: beats per packet; minimum 1.
- PRBS_SEED, 31'h0000_0001: PRBS-31 reset state; must be nonzero.
- m_axis_aclk  in  1  clock; all logic on rising edge.
- m_axis_areset  in  1  reset, asynchronous assert, active-high.
- enable  in  1  high enables beat generation.
- mode  in  2  pattern select: 0 counter, 1 PRBS-31, 2 walking-one, 3 constant.
- const_value  in  TDATA_WIDTH  data for mode 3.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tdata  out  TDATA_WIDTH  AXIS data.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tlast  out  1  AXIS last; high on the final beat of each packet.
- drop_count  out  16  saturating count of beats dropped due to backpressure.

## Operation
- Divider: divctr runs 0..DIVIDER-1. A tick fires in a cycle where enable=1 and divctr=DIVIDER-1; divctr then returns to 0. While enable=0, divctr is held at 0. With DIVIDER=1, a tick fires every enabled cycle.
- Beat load on tick: a beat is loaded when tvalid=0, or when tvalid=1 and tready=1 in the same cycle. Loading sets tvalid=1, tdata to the current pattern value and tlast to (beat_idx==PACKET_LEN-1). It then advances the active pattern and beat_idx; beat_idx wraps to 0 after PACKET_LEN-1.
- Drop on tick: a tick arriving while tvalid=1 and tready=0 is dropped. drop_count increments and saturates at 16'hFFFF. Pattern state and beat_idx do not advance, and tdata and tlast hold.
- Handshake without tick: tvalid=1 and tready=1 clears tvalid.
- Hold: while tvalid=1 and tready=0, tdata and tlast are stable.
- Mode latch: mode is sampled into active_mode only when a beat loads with beat_idx=0. Packets never mix patterns.
- Counter mode: outputs cnt zero-extended. Next value is computed at TDATA_WIDTH+1 bits: if cnt+COUNTER_INCR > COUNTER_END, next is COUNTER_START, else cnt+COUNTER_INCR. The first counter beat after reset is COUNTER_START.
- PRBS mode: the 31-bit LFSR uses x^31+x^28+1, next = {s[29:0], s[30]^s[27]}. One step per loaded beat. tdata = s zero-extended or truncated to TDATA_WIDTH. The first beat is PRBS_SEED.
- Walking-one mode: tdata = 1<<pos, with pos in 0..TDATA_WIDTH-1, wrapping after TDATA_WIDTH-1.
- Constant mode: tdata = const_value sampled at load.
- Only the active pattern's state advances. The other patterns resume from where they stopped.
- Reset, asynchronous: tvalid=0, tlast=0, tdata=0, drop_count=0, cnt=COUNTER_START, lfsr=PRBS_SEED, pos=0, beat_idx=0, divctr=0, active_mode=0.
- Reset mid-packet discards the pending beat. The next packet starts at beat_idx 0.

## Timing
- Latency: a tick at clock edge N gives tvalid/tdata/tlast valid after edge N.
- After reset release with enable=1 held: divctr counts from 0, so the first tick is at the DIVIDER-th rising edge and the first beat is visible after that edge.
- Throughput: 1 beat per DIVIDER cycles. With DIVIDER=1 and tready=1, tvalid stays high continuously and a new beat is presented every cycle.
- Simultaneous tick and handshake: the outgoing beat completes and the new beat loads in the same cycle; tvalid stays 1 and nothing is dropped.
- drop_count updates the edge after the dropping tick.
- enable deasserting does not retract a pending tvalid.
- Reset assertion clears outputs immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- Counter wrap: DIVIDER=1, START=250, END=255, INCR=2, PACKET_LEN=4, tready=1 -> tdata 250,252,254,250,252,…; tlast on beats 4, 8, …
- Backpressure drop: DIVIDER=2, tready=0 for 10 cycles after the first beat -> tdata holds the first value; drop_count=5 (ticks at cycles 4, 6, 8, 10, 12); after tready=1 the next beat is the second pattern value, with no skip.
- PRBS sequence: mode=1, seed=1, DIVIDER=1 -> beat 0 = 0x1, beat 1 = 0x2; the first 64 beats match a reference LFSR model; no zero state ever appears.
- Mode latch: switch mode 0→2 at beat_idx 2 of a 4-beat packet -> beats 2 and 3 remain counter values; the next packet is 1, 2, 4, 8.
- Simultaneous tick and handshake: DIVIDER=1, tready=1 -> tvalid stays high every cycle; drop_count stays 0.
- Async reset mid-packet: assert m_axis_areset between edges during beat 2 -> tvalid=0 and drop_count=0 immediately; after release the first beat is COUNTER_START with beat_idx 0.

Source files
------------

// File: rtl/axis_pattern_generator_mm_if.sv
// AXI4-Stream master-to-slave bundle carrying the generated pattern beats.
interface axis_pattern_generator_mm_if #(
    parameter int unsigned TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_pattern_generator_mm.sv
// Multi-mode AXI4-Stream pattern source: counter, PRBS-31, walking-one, constant.
// One beat per DIVIDER enabled clocks, fixed-length packets, undeliverable beats counted.
module axis_pattern_generator_mm #(
    parameter int unsigned TDATA_WIDTH   = 32,
    parameter int unsigned COUNTER_START = 0,
    parameter int unsigned COUNTER_END   = 255,
    parameter int unsigned COUNTER_INCR  = 1,
    parameter int unsigned DIVIDER       = 5,
    parameter int unsigned PACKET_LEN    = 16,
    parameter logic [30:0] PRBS_SEED     = 31'h0000_0001
) (
    input  logic                            m_axis_aclk,
    input  logic                            m_axis_areset,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic [TDATA_WIDTH-1:0]          const_value,
    axis_pattern_generator_mm_if.master     m_axis,
    output logic [15:0]                     drop_count
);

    localparam int unsigned DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int unsigned IDX_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int unsigned POS_W = $clog2(TDATA_WIDTH);
    localparam int unsigned EXT_W = (TDATA_WIDTH > 31) ? TDATA_WIDTH : 31;
    localparam int unsigned CNT_W = TDATA_WIDTH + 1;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'd0,
        MODE_PRBS  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    logic [DIV_W-1:0]       r_divctr;
    logic [TDATA_WIDTH-1:0] r_cnt;
    logic [30:0]            r_lfsr;
    logic [POS_W-1:0]       r_pos;
    logic [IDX_W-1:0]       r_beat_idx;
    mode_e                  r_active_mode;
    logic                   r_tvalid;
    logic                   r_tlast;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic [15:0]            r_drop_count;

    logic                   w_tick;
    logic                   w_load;
    logic                   w_drop;
    logic                   w_first_beat;
    logic                   w_last_beat;
    mode_e                  w_mode_sel;
    logic [CNT_W-1:0]       w_cnt_sum;
    logic [TDATA_WIDTH-1:0] w_cnt_next;
    logic [30:0]            w_lfsr_next;
    logic [POS_W-1:0]       w_pos_next;
    logic [IDX_W-1:0]       w_idx_next;
    logic [EXT_W-1:0]       w_lfsr_ext;
    logic [TDATA_WIDTH-1:0] w_prbs_data;
    logic [TDATA_WIDTH-1:0] w_walk_data;
    logic [TDATA_WIDTH-1:0] w_pattern;

    // Beat timing and load/drop decision
    assign w_tick       = enable && (r_divctr == DIV_W'(DIVIDER - 1));
    assign w_load       = w_tick && (!r_tvalid || m_axis.tready);
    assign w_drop       = w_tick && r_tvalid && !m_axis.tready;
    assign w_first_beat = (r_beat_idx == '0);
    assign w_last_beat  = (r_beat_idx == IDX_W'(PACKET_LEN - 1));
    assign w_mode_sel   = w_first_beat ? mode_e'(mode) : r_active_mode;

    // Next-state for each pattern generator
    assign w_cnt_sum   = {1'b0, r_cnt} + CNT_W'(COUNTER_INCR);
    assign w_cnt_next  = (w_cnt_sum > CNT_W'(COUNTER_END)) ? TDATA_WIDTH'(COUNTER_START)
                                                           : w_cnt_sum[TDATA_WIDTH-1:0];
    assign w_lfsr_next = {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
    assign w_pos_next  = (r_pos == POS_W'(TDATA_WIDTH - 1)) ? '0 : r_pos + POS_W'(1);
    assign w_idx_next  = w_last_beat ? '0 : r_beat_idx + IDX_W'(1);

    // PRBS state is 31 bits wide; pad or truncate to the bus width
    assign w_lfsr_ext  = EXT_W'(r_lfsr);
    assign w_prbs_data = w_lfsr_ext[TDATA_WIDTH-1:0];
    assign w_walk_data = TDATA_WIDTH'(1) << r_pos;

    always_comb begin
        w_pattern = r_cnt;
        case (w_mode_sel)
            MODE_CNT:   w_pattern = r_cnt;
            MODE_PRBS:  w_pattern = w_prbs_data;
            MODE_WALK:  w_pattern = w_walk_data;
            MODE_CONST: w_pattern = const_value;
            default:    w_pattern = r_cnt;
        endcase
    end

    // Divider: held at zero while disabled, restarts after every tick
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            r_divctr <= '0;
        end else if (!enable || w_tick) begin
            r_divctr <= '0;
        end else begin
            r_divctr <= r_divctr + DIV_W'(1);
        end
    end

    // Output beat register and AXIS valid handling
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_beat_idx    <= '0;
            r_active_mode <= MODE_CNT;
        end else if (w_load) begin
            r_tvalid      <= 1'b1;
            r_tlast       <= w_last_beat;
            r_tdata       <= w_pattern;
            r_beat_idx    <= w_idx_next;
            r_active_mode <= w_mode_sel;
        end else if (r_tvalid && m_axis.tready) begin
            r_tvalid      <= 1'b0;
        end
    end

    // Only the pattern feeding the loaded beat advances
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            r_cnt  <= TDATA_WIDTH'(COUNTER_START);
            r_lfsr <= PRBS_SEED;
            r_pos  <= '0;
        end else if (w_load) begin
            case (w_mode_sel)
                MODE_CNT:  r_cnt  <= w_cnt_next;
                MODE_PRBS: r_lfsr <= w_lfsr_next;
                MODE_WALK: r_pos  <= w_pos_next;
                default:   r_cnt  <= r_cnt;
            endcase
        end
    end

    // Saturating count of ticks lost to backpressure
    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign drop_count    = r_drop_count;

endmodule
